// File: rtl/matrix_dot_sequencer.sv
// Sequencer that streams PORTS-wide operand groups through a lane multiplier/adder
// accelerator, reduces the lane sums and returns one dot-product result per command.
module matrix_dot_sequencer #(
    parameter int PORTS   = 4,
    parameter int BITLEN  = 32,
    parameter int LEN_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                      Clk,
    input  logic                      Rst,
    // cmd, op and res channels are valid/ready: a transfer happens on a rising edge
    // where both are high; the valid side holds its payload stable until then.
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [PORTS*BITLEN-1:0]   a_data,
    input  logic [PORTS*BITLEN-1:0]   b_data,
    output logic [PORTS*BITLEN-1:0]   multiplier_input,
    output logic [PORTS*BITLEN-1:0]   multiplicand_input,
    output logic [PORTS-1:0]          mStart,
    input  logic [PORTS-1:0]          mReady,
    output logic [PORTS-1:0]          Add,
    output logic                      direct,
    output logic                      finalAdd,
    input  logic [2*BITLEN-1:0]       finalAccumulate,
    input  logic                      finalReady,
    output logic                      acc_clr,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*BITLEN-1:0]       res_data,
    output logic                      res_err,
    output logic                      busy,
    output logic [3:0]                dbg_state
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] CLEAR      = 4'd1;
    localparam logic [3:0] LOAD       = 4'd2;
    localparam logic [3:0] MULT       = 4'd3;
    localparam logic [3:0] ACCUM      = 4'd4;
    localparam logic [3:0] REDUCE     = 4'd5;
    localparam logic [3:0] WAIT_FINAL = 4'd6;
    localparam logic [3:0] SETTLE     = 4'd7;
    localparam logic [3:0] OUT        = 4'd8;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int RED_W  = $clog2(PORTS + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [RED_W-1:0]  RED_LAST  = RED_W'(PORTS - 1);

    logic [3:0]        state;
    logic [3:0]        next_state;
    logic [LEN_W-1:0]  remaining;
    logic [WAIT_W-1:0] wait_cnt;
    logic [RED_W-1:0]  reduce_cnt;
    logic              mult_first;
    logic              wait_expired;

    assign direct       = 1'b1;
    assign dbg_state    = state;
    assign wait_expired = (wait_cnt == TIMEOUT_V);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    next_state = (cmd_len != '0) ? CLEAR : OUT;
                end
            end
            CLEAR: next_state = LOAD;
            LOAD: begin
                if (op_valid) begin
                    next_state = MULT;
                end
            end
            MULT: begin
                // mReady may still be high from the previous group on the start cycle.
                if (!mult_first) begin
                    if (&mReady) begin
                        next_state = ACCUM;
                    end else if (wait_expired) begin
                        next_state = OUT;
                    end
                end
            end
            ACCUM: next_state = (remaining == LEN_W'(1)) ? REDUCE : LOAD;
            REDUCE: begin
                if (reduce_cnt == RED_LAST) begin
                    next_state = WAIT_FINAL;
                end
            end
            WAIT_FINAL: begin
                if (finalReady) begin
                    next_state = SETTLE;
                end else if (wait_expired) begin
                    next_state = OUT;
                end
            end
            SETTLE: next_state = OUT;
            OUT: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so they line up with the state they belong to.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state              <= IDLE;
            cmd_ready          <= 1'b0;
            op_ready           <= 1'b0;
            acc_clr            <= 1'b0;
            mStart             <= '0;
            mult_first         <= 1'b0;
            Add                <= '0;
            finalAdd           <= 1'b0;
            res_valid          <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state              <= next_state;
            cmd_ready          <= (next_state == IDLE);
            op_ready           <= (next_state == LOAD);
            acc_clr            <= (next_state == CLEAR);
            mStart             <= {PORTS{(next_state == MULT) && (state != MULT)}};
            mult_first         <= (next_state == MULT) && (state != MULT);
            Add                <= {PORTS{next_state == ACCUM}};
            finalAdd           <= (next_state == REDUCE);
            res_valid          <= (next_state == OUT);
            busy               <= (next_state != IDLE);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            remaining          <= '0;
            wait_cnt           <= '0;
            reduce_cnt         <= '0;
            multiplier_input   <= '0;
            multiplicand_input <= '0;
            res_data           <= '0;
            res_err            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            res_data <= '0;
                            res_err  <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (op_valid) begin
                        multiplier_input   <= a_data;
                        multiplicand_input <= b_data;
                    end
                end
                MULT: begin
                    if (mult_first) begin
                        wait_cnt <= WAIT_W'(1);
                    end else if (!(&mReady)) begin
                        if (wait_expired) begin
                            res_data <= '0;
                            res_err  <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    remaining  <= remaining - LEN_W'(1);
                    reduce_cnt <= '0;
                end
                REDUCE: begin
                    if (reduce_cnt == RED_LAST) begin
                        wait_cnt <= WAIT_W'(1);
                    end else begin
                        reduce_cnt <= reduce_cnt + RED_W'(1);
                    end
                end
                WAIT_FINAL: begin
                    if (!finalReady) begin
                        if (wait_expired) begin
                            res_data <= '0;
                            res_err  <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    res_data <= finalAccumulate;
                    res_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_dot_sequencer.sv
// Bench for matrix_dot_sequencer: a behavioural accelerator model answers the strobes,
// and each result is compared with a dot product computed directly from the operands.
module tb_matrix_dot_sequencer;

  localparam int PORTS   = 4;
  localparam int BITLEN  = 32;
  localparam int LEN_W   = 5;
  localparam int TIMEOUT = 255;
  localparam int W2      = 2 * BITLEN;
  localparam int BOUND   = 2000;
  localparam logic [PORTS-1:0] ALL = {PORTS{1'b1}};

  // clock / reset
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [LEN_W-1:0]        cmd_len = '0;
  logic                    op_valid = 1'b0;
  logic                    op_ready;
  logic [PORTS*BITLEN-1:0] a_data = '0;
  logic [PORTS*BITLEN-1:0] b_data = '0;
  logic [PORTS*BITLEN-1:0] multiplier_input;
  logic [PORTS*BITLEN-1:0] multiplicand_input;
  logic [PORTS-1:0]        mStart;
  logic [PORTS-1:0]        mReady = '0;
  logic [PORTS-1:0]        Add;
  logic                    direct;
  logic                    finalAdd;
  logic [W2-1:0]           finalAccumulate = '0;
  logic                    finalReady = 1'b0;
  logic                    acc_clr;
  logic                    res_valid;
  logic                    res_ready = 1'b1;
  logic [W2-1:0]           res_data;
  logic                    res_err;
  logic                    busy;
  logic [3:0]              dbg_state;

  matrix_dot_sequencer #(
    .PORTS(PORTS), .BITLEN(BITLEN), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .a_data(a_data), .b_data(b_data),
    .multiplier_input(multiplier_input), .multiplicand_input(multiplicand_input),
    .mStart(mStart), .mReady(mReady), .Add(Add), .direct(direct),
    .finalAdd(finalAdd), .finalAccumulate(finalAccumulate), .finalReady(finalReady),
    .acc_clr(acc_clr), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  logic [PORTS*BITLEN-1:0] a_grp [32];
  logic [PORTS*BITLEN-1:0] b_grp [32];

  // accelerator model: per-lane multiply with random latency, per-lane adders, final reduce
  bit            hold_mready = 1'b0;
  bit            hold_final  = 1'b0;
  logic [W2-1:0] lane_acc [PORTS];
  logic [W2-1:0] prod [PORTS];
  int            lane_cnt [PORTS];
  int            fin_cnt  = 0;
  int            fin_wait = 0;

  always @(negedge Clk) begin
    if (!Rst) begin
      for (int n = 0; n < PORTS; n++) begin
        lane_acc[n] = '0; prod[n] = '0; lane_cnt[n] = 0;
      end
      mReady = '0; fin_cnt = 0; fin_wait = 0;
      finalReady = 1'b0; finalAccumulate = '0;
    end else begin
      if (acc_clr) begin
        for (int n = 0; n < PORTS; n++) lane_acc[n] = '0;
        fin_cnt = 0; fin_wait = 0; finalReady = 1'b0;
      end
      if (mStart != '0) begin
        for (int n = 0; n < PORTS; n++) begin
          prod[n] = W2'(multiplier_input[n*BITLEN +: BITLEN]) *
                    W2'(multiplicand_input[n*BITLEN +: BITLEN]);
          mReady[n] = 1'b0;
          lane_cnt[n] = hold_mready ? 0 : int'($urandom_range(1, 4));
        end
      end else begin
        for (int n = 0; n < PORTS; n++) begin
          if (lane_cnt[n] > 0) begin
            lane_cnt[n]--;
            if (lane_cnt[n] == 0) mReady[n] = 1'b1;
          end
        end
      end
      for (int n = 0; n < PORTS; n++) if (Add[n]) lane_acc[n] += prod[n];
      if (finalAdd) begin
        fin_cnt++;
        if (fin_cnt == PORTS && !hold_final) fin_wait = int'($urandom_range(1, 4));
      end else if (fin_wait > 0) begin
        fin_wait--;
        if (fin_wait == 0) begin
          finalReady = 1'b1;
          finalAccumulate = '0;
          for (int n = 0; n < PORTS; n++) finalAccumulate += lane_acc[n];
        end
      end
    end
  end

  // event monitor
  int n_clr = 0, n_mstart = 0, n_add = 0, n_fadd = 0, n_bad_pulse = 0, n_bubble = 0, n_resv = 0;
  bit add_prev = 1'b0;

  always @(negedge Clk) begin
    if (!Rst) begin
      add_prev = 1'b0;
    end else begin
      if (acc_clr) n_clr++;
      if (mStart != '0) begin n_mstart++; if (mStart != ALL) n_bad_pulse++; end
      if (Add != '0) begin n_add++; if (Add != ALL) n_bad_pulse++; end
      if (finalAdd) n_fadd++;
      if (add_prev && !(op_ready || finalAdd)) n_bubble++;
      add_prev = (Add != '0);
      if (res_valid) n_resv++;
    end
  end

  // reference: dot product straight from the operand groups
  function automatic logic [W2-1:0] ref_dot(input int len);
    logic [W2-1:0] s;
    logic [BITLEN-1:0] x, y;
    s = '0;
    for (int g = 0; g < len; g++)
      for (int n = 0; n < PORTS; n++) begin
        x = a_grp[g][n*BITLEN +: BITLEN];
        y = b_grp[g][n*BITLEN +: BITLEN];
        s += W2'(x) * W2'(y);
      end
    return s;
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic fill_random(input int len);
    for (int g = 0; g < len; g++)
      for (int n = 0; n < PORTS; n++) begin
        a_grp[g][n*BITLEN +: BITLEN] = BITLEN'($urandom);
        b_grp[g][n*BITLEN +: BITLEN] = BITLEN'($urandom);
      end
  endtask

  task automatic send_cmd(input int len);
    int n = 0;
    cmd_len = LEN_W'(len);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < BOUND) begin tick(); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_wait: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  int n_opr_drop = 0;

  task automatic send_group(input int g, input int delay);
    int n = 0;
    op_valid = 1'b0;
    while (!op_ready && n < BOUND) begin tick(); n++; end
    if (!op_ready) begin
      checks++; errors++;
      $display("FAIL op_wait: op_ready=%0b after %0d cycles, required 1", op_ready, n);
    end
    for (int d = 0; d < delay; d++) begin
      tick();
      if (!op_ready) n_opr_drop++;
    end
    a_data = a_grp[g];
    b_data = b_grp[g];
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic get_result(output logic [W2-1:0] data, output logic err);
    int n = 0;
    while (!res_valid && n < BOUND) begin tick(); n++; end
    data = res_data;
    err = res_err;
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL res_wait: res_valid=%0b after %0d cycles, required 1", res_valid, n);
    end
    if (res_ready) tick();
  endtask

  task automatic run_cmd(input int len, input int delay, output logic [W2-1:0] data,
                         output logic err);
    send_cmd(len);
    for (int g = 0; g < len; g++)
      send_group(g, (delay < 0) ? int'($urandom_range(0, 3)) : delay);
    get_result(data, err);
  endtask

  // scenario tasks
  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({cmd_ready, op_ready, acc_clr, finalAdd, res_valid, res_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: {cmd_rdy,op_rdy,clr,fadd,rv,err,busy}=%b required 0",
               {cmd_ready, op_ready, acc_clr, finalAdd, res_valid, res_err, busy});
    end
    checks++;
    if ({mStart, Add} !== '0) begin
      errors++; $display("FAIL reset_strobes: mStart=%h Add=%h required 0", mStart, Add);
    end
    checks++;
    if ({multiplier_input, multiplicand_input, res_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: mult=%h mcand=%h res=%h required 0",
               multiplier_input, multiplicand_input, res_data);
    end
    checks++;
    if (direct !== 1'b1) begin
      errors++; $display("FAIL reset_direct: direct=%b required 1", direct);
    end
    Rst = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [W2-1:0] d;
    logic e;
    int c_clr = n_clr, c_ms = n_mstart, c_add = n_add, c_fa = n_fadd, c_bad = n_bad_pulse;
    for (int n = 0; n < PORTS; n++) begin
      a_grp[0][n*BITLEN +: BITLEN] = BITLEN'(n + 1);
      b_grp[0][n*BITLEN +: BITLEN] = BITLEN'(n + 1);
    end
    run_cmd(1, 0, d, e);
    checks++;
    if (n_clr - c_clr != 1) begin errors++; $display("FAIL single_clr: count=%0d required 1", n_clr - c_clr); end
    checks++;
    if (n_mstart - c_ms != 1) begin errors++; $display("FAIL single_mstart: count=%0d required 1", n_mstart - c_ms); end
    checks++;
    if (n_add - c_add != 1) begin errors++; $display("FAIL single_add: count=%0d required 1", n_add - c_add); end
    checks++;
    if (n_fadd - c_fa != PORTS) begin errors++; $display("FAIL single_fadd: count=%0d required %0d", n_fadd - c_fa, PORTS); end
    checks++;
    if (n_bad_pulse != c_bad) begin errors++; $display("FAIL single_pulse_width: partial-lane pulses=%0d required 0", n_bad_pulse - c_bad); end
    checks++;
    if (d !== W2'(30) || e !== 1'b0) begin
      errors++; $display("FAIL single_result: data=%0d err=%b required 30/0", d, e);
    end
  endtask

  task automatic test_delayed();
    logic [W2-1:0] d;
    logic e;
    int c_add = n_add, c_bub = n_bubble;
    n_opr_drop = 0;
    fill_random(3);
    run_cmd(3, 5, d, e);
    checks++;
    if (n_opr_drop != 0) begin errors++; $display("FAIL delayed_op_ready: drops=%0d required 0", n_opr_drop); end
    checks++;
    if (n_add - c_add != 3) begin errors++; $display("FAIL delayed_add: count=%0d required 3", n_add - c_add); end
    checks++;
    if (n_bubble != c_bub) begin errors++; $display("FAIL delayed_bubble: count=%0d required 0", n_bubble - c_bub); end
    checks++;
    if (d !== ref_dot(3) || e !== 1'b0) begin
      errors++; $display("FAIL delayed_result: data=%h err=%b required %h/0", d, e, ref_dot(3));
    end
  endtask

  task automatic test_zero_len();
    logic [W2-1:0] d;
    logic e;
    int c_clr = n_clr, c_ms = n_mstart, c_fa = n_fadd;
    send_cmd(0);
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL zero_latency: res_valid=%b required 1", res_valid); end
    get_result(d, e);
    checks++;
    if (d !== '0 || e !== 1'b0) begin errors++; $display("FAIL zero_result: data=%h err=%b required 0/0", d, e); end
    checks++;
    if (n_clr != c_clr || n_mstart != c_ms || n_fadd != c_fa) begin
      errors++;
      $display("FAIL zero_strobes: clr=%0d mstart=%0d fadd=%0d required 0",
               n_clr - c_clr, n_mstart - c_ms, n_fadd - c_fa);
    end
  endtask

  task automatic test_timeout();
    logic [W2-1:0] d;
    logic e;
    int n = 0;
    hold_mready = 1'b1;
    fill_random(1);
    send_cmd(1);
    send_group(0, 0);
    checks++;
    if (mStart !== ALL) begin errors++; $display("FAIL tmo_start: mStart=%h required %h", mStart, ALL); end
    while (!res_valid && n < BOUND) begin tick(); n++; end
    checks++;
    if (n != TIMEOUT + 1) begin
      errors++; $display("FAIL tmo_latency: cycles=%0d required %0d", n, TIMEOUT + 1);
    end
    get_result(d, e);
    checks++;
    if (d !== '0 || e !== 1'b1) begin errors++; $display("FAIL tmo_result: data=%h err=%b required 0/1", d, e); end
    hold_mready = 1'b0;
    fill_random(2);
    run_cmd(2, -1, d, e);
    checks++;
    if (d !== ref_dot(2) || e !== 1'b0) begin
      errors++; $display("FAIL tmo_recover: data=%h err=%b required %h/0", d, e, ref_dot(2));
    end
  endtask

  task automatic test_final_timeout();
    logic [W2-1:0] d;
    logic e;
    hold_final = 1'b1;
    fill_random(1);
    run_cmd(1, 0, d, e);
    checks++;
    if (d !== '0 || e !== 1'b1) begin errors++; $display("FAIL final_tmo: data=%h err=%b required 0/1", d, e); end
    hold_final = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W2-1:0] d;
    logic e;
    int bad = 0;
    res_ready = 1'b0;
    fill_random(2);
    run_cmd(2, 1, d, e);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== d || cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: unstable cycles=%0d required 0", bad); end
    checks++;
    if (d !== ref_dot(2) || e !== 1'b0) begin
      errors++; $display("FAIL bp_result: data=%h err=%b required %h/0", d, e, ref_dot(2));
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: res_valid=%b cmd_ready=%b required 0/1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [W2-1:0] d;
    logic e;
    int c_rv, c_clr;
    fill_random(2);
    send_cmd(2);
    send_group(0, 0);
    Rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, op_ready, acc_clr, finalAdd, res_valid, res_err, busy, mStart, Add} !== '0 ||
        {multiplier_input, multiplicand_input, res_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_zero: ctrl=%b mStart=%h Add=%h mult=%h res=%h required 0",
               {cmd_ready, op_ready, acc_clr, finalAdd, res_valid, res_err, busy},
               mStart, Add, multiplier_input, res_data);
    end
    checks++;
    if (direct !== 1'b1) begin errors++; $display("FAIL mid_reset_direct: direct=%b required 1", direct); end
    c_rv = n_resv;
    for (int i = 0; i < 3; i++) tick();
    Rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (n_resv != c_rv) begin errors++; $display("FAIL mid_no_result: res_valid cycles=%0d required 0", n_resv - c_rv); end
    c_clr = n_clr;
    fill_random(2);
    send_cmd(2);
    checks++;
    if (acc_clr !== 1'b1) begin errors++; $display("FAIL mid_clear: acc_clr=%b required 1", acc_clr); end
    for (int g = 0; g < 2; g++) send_group(g, 0);
    get_result(d, e);
    checks++;
    if (n_clr - c_clr != 1 || d !== ref_dot(2) || e !== 1'b0) begin
      errors++;
      $display("FAIL mid_recover: clr=%0d data=%h err=%b required 1/%h/0", n_clr - c_clr, d, e, ref_dot(2));
    end
  endtask

  task automatic test_random();
    logic [W2-1:0] d;
    logic e;
    int len;
    for (int i = 0; i < 8; i++) begin
      len = int'($urandom_range(1, 6));
      fill_random(len);
      run_cmd(len, -1, d, e);
      checks++;
      if (d !== ref_dot(len) || e !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: len=%0d data=%h err=%b required %h/0", i, len, d, e, ref_dot(len));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_delayed();
    test_zero_len();
    test_timeout();
    test_final_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
